// File: rtl/sha256_pkg.sv
// Shared SHA-256 message-schedule definitions: state encoding, sizes, tap offsets
// and the sigma0/sigma1 schedule functions.
package sha256_pkg;

  localparam int unsigned NUM_ROUNDS  = 64;
  localparam int unsigned SCHED_DEPTH = 16;
  localparam int unsigned WORD_W      = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_DONE
  } sched_state_t;

  // Tap offsets into the 16-entry ring, relative to t: W[t-2], W[t-7], W[t-15], W[t-16]
  localparam logic [3:0] TAP_S1  = 4'd14;
  localparam logic [3:0] TAP_W7  = 4'd9;
  localparam logic [3:0] TAP_S0  = 4'd1;
  localparam logic [3:0] TAP_W16 = 4'd0;

  function automatic word_t sigma0(input word_t x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic word_t sigma1(input word_t x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

endpackage

// File: rtl/sha256_sched_word_calc.sv
// Combinational SHA-256 schedule expansion: W[t] from the four tap words.
module sha256_sched_word_calc
  import sha256_pkg::*;
(
  input  word_t w_m2,
  input  word_t w_m7,
  input  word_t w_m15,
  input  word_t w_m16,
  output word_t w_new
);

  word_t s1_term;
  word_t s0_term;

  always_comb begin
    s1_term = sigma1(w_m2);
    s0_term = sigma0(w_m15);
  end

  assign w_new = s1_term + w_m7 + s0_term + w_m16;

endmodule

// File: rtl/sha256_msg_schedule_ctrl.sv
// SHA-256 message-schedule sequencer: loads 16 words, emits W[0..63] over valid/ready.
// Optional macro SHA256_SCHED_ABORT_EN adds an `abort` input that cancels LOAD/RUN.
module sha256_msg_schedule_ctrl #(
  parameter int unsigned NUM_ROUNDS = sha256_pkg::NUM_ROUNDS,
  parameter int unsigned WORD_W     = sha256_pkg::WORD_W
) (
  input  logic              clk,
  input  logic              rst,
`ifdef SHA256_SCHED_ABORT_EN
  input  logic              abort,
`endif
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_word,
  output logic              w_valid,
  input  logic              w_ready,
  output logic [WORD_W-1:0] w_word,
  output logic [5:0]        w_round,
  output logic              busy,
  output logic              done
);

  import sha256_pkg::*;

  localparam logic [5:0] LAST_T  = 6'(NUM_ROUNDS - 1);
  localparam logic [5:0] FIRST_X = 6'(SCHED_DEPTH);

  sched_state_t state_q, state_d;
  logic [3:0]   load_cnt_q, load_cnt_d;
  logic [5:0]   t_q, t_d;

  word_t        sched_buf [SCHED_DEPTH];
  logic         buf_we;
  logic [3:0]   buf_waddr;
  word_t        buf_wdata;

  logic [3:0]   t_idx;
  word_t        calc_word;
  word_t        sel_word;
  logic         abort_req;

`ifdef SHA256_SCHED_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  assign t_idx = t_q[3:0];

  sha256_sched_word_calc u_word_calc (
    .w_m2  (sched_buf[t_idx + TAP_S1]),
    .w_m7  (sched_buf[t_idx + TAP_W7]),
    .w_m15 (sched_buf[t_idx + TAP_S0]),
    .w_m16 (sched_buf[t_idx + TAP_W16]),
    .w_new (calc_word)
  );

  assign sel_word = (t_q < FIRST_X) ? sched_buf[t_idx] : calc_word;
  assign w_word   = (state_q == ST_RUN) ? WORD_W'(sel_word) : '0;
  assign w_round  = t_q;

  always_comb begin
    state_d    = state_q;
    load_cnt_d = load_cnt_q;
    t_d        = t_q;
    buf_we     = 1'b0;
    buf_waddr  = '0;
    buf_wdata  = word_t'(in_word);
    in_ready   = 1'b0;
    w_valid    = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          buf_we     = 1'b1;
          buf_waddr  = '0;
          load_cnt_d = 4'd1;
          state_d    = ST_LOAD;
        end
      end
      ST_LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (abort_req) begin
          load_cnt_d = '0;
          t_d        = '0;
          state_d    = ST_IDLE;
        end else if (in_valid) begin
          buf_we     = 1'b1;
          buf_waddr  = load_cnt_q;
          load_cnt_d = load_cnt_q + 4'd1;
          if (load_cnt_q == 4'd15) begin
            t_d     = '0;
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        w_valid = 1'b1;
        busy    = 1'b1;
        if (abort_req) begin
          load_cnt_d = '0;
          t_d        = '0;
          state_d    = ST_IDLE;
        end else if (w_ready) begin
          // Expanded word overwrites the slot of W[t-16], which is no longer needed
          buf_we    = (t_q >= FIRST_X);
          buf_waddr = t_idx;
          buf_wdata = calc_word;
          if (t_q == LAST_T) begin
            state_d = ST_DONE;
          end else begin
            t_d = t_q + 6'd1;
          end
        end
      end
      ST_DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        load_cnt_d = '0;
        t_d        = '0;
        state_d    = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      load_cnt_q <= '0;
      t_q        <= '0;
    end else begin
      state_q    <= state_d;
      load_cnt_q <= load_cnt_d;
      t_q        <= t_d;
    end
  end

  always_ff @(posedge clk) begin
    if (buf_we) begin
      sched_buf[buf_waddr] <= buf_wdata;
    end
  end

endmodule

// File: tb/tb_sha256_msg_schedule_ctrl.sv
// Scoreboard bench for sha256_msg_schedule_ctrl; covers the abort port when
// SHA256_SCHED_ABORT_EN is defined.
module tb_sha256_msg_schedule_ctrl;

  typedef logic [31:0] blk_t [16];

  logic        clk = 1'b0;
  logic        rst;
  logic        abort;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_word;
  logic        w_valid;
  logic        w_ready;
  logic [31:0] w_word;
  logic [5:0]  w_round;
  logic        busy;
  logic        done;

  int          n_total = 0;
  int          n_pass  = 0;
  int          cyc     = 0;
  logic [37:0] sb [$];
  logic [31:0] ref_w [64];
  logic [31:0] obs [64];

  sha256_msg_schedule_ctrl #(.NUM_ROUNDS(64), .WORD_W(32)) dut (
    .clk      (clk),
    .rst      (rst),
`ifdef SHA256_SCHED_ABORT_EN
    .abort    (abort),
`endif
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_word  (in_word),
    .w_valid  (w_valid),
    .w_ready  (w_ready),
    .w_word   (w_word),
    .w_round  (w_round),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    else
      n_pass++;
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ref_s0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ref_s1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  task automatic push_ref(input blk_t blk);
    for (int i = 0; i < 64; i++) begin
      if (i < 16) ref_w[i] = blk[i];
      else ref_w[i] = ref_s1(ref_w[i-2]) + ref_w[i-7] + ref_s0(ref_w[i-15]) + ref_w[i-16];
      sb.push_back({6'(i), ref_w[i]});
    end
  endtask

  task automatic load_block(input blk_t blk, input int gap_pct, input int nwords, output int first_cyc);
    first_cyc = 0;
    for (int i = 0; i < nwords; i++) begin
      while ($urandom_range(99) < gap_pct) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_word  = blk[i];
      check_val("in_ready_load", in_ready, 1'b1);
      if (i == 0) first_cyc = cyc;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (nwords == 16) check_val("first_wvalid_lat1", {w_valid, w_round}, {1'b1, 6'd0});
  endtask

  task automatic collect(input int stall_pct, input bit garbage, input int rst_round, output int done_cyc);
    int          budget;
    bit          stalled;
    bit          fin;
    int          bad_ready;
    logic [31:0] pw;
    logic [5:0]  pr;
    logic [37:0] e;
    budget = 0; stalled = 0; fin = 0; bad_ready = 0; done_cyc = 0; pw = '0; pr = '0;
    if (garbage) begin
      in_valid = 1'b1;
      in_word  = 32'hDEADBEEF;
    end
    while (!fin && budget < 3000) begin
      if (stalled) begin
        check_val("hold_word", w_word, pw);
        check_val("hold_round", w_round, pr);
      end
      if (garbage && w_valid && in_ready) bad_ready++;
      if (done) begin
        done_cyc = cyc;
        check_val("done_wvalid_low", {w_valid, in_ready}, 2'b00);
        in_valid = 1'b0;
        w_ready  = 1'b0;
        fin      = 1;
      end else if (w_valid && rst_round >= 0 && int'(w_round) == rst_round) begin
        rst = 1'b1;
        #1;
        check_val("rst_mid_run", {in_ready, w_valid, w_word, w_round, busy, done},
                  {1'b1, 1'b0, 32'h0, 6'h0, 1'b0, 1'b0});
        sb.delete();
        in_valid = 1'b0;
        fin = 1;
      end else begin
        w_ready = ($urandom_range(99) >= stall_pct);
        if (w_valid && w_ready) begin
          if (sb.size() == 0) begin
            check_val("sb_underflow", 1, 0);
          end else begin
            e = sb.pop_front();
            check_val("w_round", w_round, e[37:32]);
            check_val("w_word", w_word, e[31:0]);
            obs[w_round] = w_word;
          end
          stalled = 0;
        end else begin
          stalled = w_valid;
          pw = w_word;
          pr = w_round;
        end
      end
      if (!fin) begin
        @(posedge clk); #1;
        budget++;
      end
    end
    if (!fin) check_val("timeout", 0, 1);
    in_valid = 1'b0;
    if (garbage) check_val("in_ready_run_low", bad_ready, 0);
  endtask

  task automatic post_done();
    @(posedge clk); #1;
    check_val("done_one_pulse", {done, in_ready, busy, w_valid}, 4'b0100);
    check_val("sb_empty", sb.size(), 0);
  endtask

  initial begin
    blk_t abc, zero, rnd;
    int   fc, dc;
    for (int i = 0; i < 16; i++) begin
      abc[i]  = 32'h0;
      zero[i] = 32'h0;
      rnd[i]  = $urandom;
    end
    abc[0]  = 32'h61626380;
    abc[15] = 32'h00000018;

    rst = 1'b1; abort = 1'b0; in_valid = 1'b0; in_word = '0; w_ready = 1'b0;
    #3;
    check_val("reset_vals", {in_ready, w_valid, w_word, w_round, busy, done},
              {1'b1, 1'b0, 32'h0, 6'h0, 1'b0, 1'b0});
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // "abc" block at full rate
    push_ref(abc);
    load_block(abc, 0, 16, fc);
    collect(0, 0, -1, dc);
    check_val("abc_w0", obs[0], 32'h61626380);
    check_val("abc_w15", obs[15], 32'h00000018);
    check_val("abc_w16", obs[16], 32'h61626380);
    check_val("abc_w17", obs[17], 32'h000F0000);
    post_done();

    // all-zero block; inclusive count from the cycle presenting word 0 to the DONE cycle
    push_ref(zero);
    load_block(zero, 0, 16, fc);
    collect(0, 0, -1, dc);
    check_val("zero_cycles", dc - fc + 1, 81);
    post_done();

    // random block with input gaps and output back-pressure
    push_ref(rnd);
    load_block(rnd, 30, 16, fc);
    collect(30, 0, -1, dc);
    post_done();

    // reset mid-RUN then a fresh "abc" block
    push_ref(abc);
    load_block(abc, 0, 16, fc);
    collect(0, 0, 30, dc);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_val("no_done_after_rst", {done, w_valid, busy}, 3'b000);
    end
    push_ref(abc);
    load_block(abc, 0, 16, fc);
    collect(20, 0, -1, dc);
    check_val("rst_abc_w17", obs[17], 32'h000F0000);
    post_done();

    // garbage on the input during RUN
    push_ref(rnd);
    load_block(rnd, 0, 16, fc);
    collect(10, 1, -1, dc);
    post_done();

`ifdef SHA256_SCHED_ABORT_EN
    // abort mid-LOAD, simultaneous with an offered word, then reload "abc"
    load_block(rnd, 0, 7, fc);
    abort = 1'b1; in_valid = 1'b1; in_word = 32'hDEADBEEF;
    @(posedge clk); #1;
    abort = 1'b0; in_valid = 1'b0;
    check_val("abort_to_idle", {busy, in_ready, done}, 3'b010);
    push_ref(abc);
    load_block(abc, 0, 16, fc);
    collect(0, 0, -1, dc);
    check_val("abort_abc_w17", obs[17], 32'h000F0000);
    post_done();
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
